// File: rtl/btb_pkg.sv
// Shared types and sizing helpers for the branch target buffer.
// Counter storage exists only when BTB_SAT_COUNTER_EN is defined.
package btb_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   localparam ctr_e CTR_RST   = WNT;
   localparam ctr_e CTR_ALLOC = WT;

   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic int tag_w(input int addr_w, input int entries);
      return addr_w - $clog2(entries) - 2;
   endfunction

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_ENTRIES = 16;
   localparam int DEF_TAG_W   = DEF_ADDR_W - $clog2(DEF_ENTRIES) - 2;

   // Entry layout for the default core configuration.
   typedef struct packed {
      logic                  valid;
      logic [DEF_TAG_W-1:0]  tag;
      logic [DEF_ADDR_W-1:0] target;
      ctr_e                  ctr;
   } btb_entry_t;

endpackage

// File: rtl/btb_target_adder.sv
// Branch target adder: pc + (imm << IMM_SHIFT), wrapping.
// Shared with decode for early target computation.
module btb_target_adder #(
   parameter int ADDR_W    = 32,
   parameter int IMM_SHIFT = 1
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] imm_i,
   output logic [ADDR_W-1:0] sum_o
);

   assign sum_o = pc_i + (imm_i << IMM_SHIFT);

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with combinational lookup and registered mispredict.
// Define BTB_SAT_COUNTER_EN for 2-bit saturating direction counters.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int ENTRIES   = 16,
   parameter int IMM_SHIFT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              lk_hit,
   output logic              lk_taken,
   output logic [ADDR_W-1:0] lk_target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_imm,
   input  logic              upd_taken,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   input  logic              flush,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc
);

   localparam int IW = idx_w(ENTRIES);
   localparam int TW = tag_w(ADDR_W, ENTRIES);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TW-1:0]      tag_q [ENTRIES];
   logic [ADDR_W-1:0]  tgt_q [ENTRIES];
   logic               mis_q, mis_d;
   logic [ADDR_W-1:0]  redir_q, redir_d;

   logic [IW-1:0]     lk_idx, up_idx;
   logic [TW-1:0]     lk_tag, up_tag;
   logic [ADDR_W-1:0] up_tgt;
   logic              up_hit, cond, wr_en;
   logic              unused_lk;

   assign lk_idx    = lk_pc[IW+1:2];
   assign lk_tag    = lk_pc[ADDR_W-1:IW+2];
   assign up_idx    = upd_pc[IW+1:2];
   assign up_tag    = upd_pc[ADDR_W-1:IW+2];
   assign unused_lk = ^lk_pc[1:0];

   assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_target = lk_hit ? tgt_q[lk_idx] : '0;

   btb_target_adder #(
      .ADDR_W   (ADDR_W),
      .IMM_SHIFT(IMM_SHIFT)
   ) u_add (
      .pc_i (upd_pc),
      .imm_i(upd_imm),
      .sum_o(up_tgt)
   );

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign cond   = (upd_taken != upd_pred_taken) ||
                   (upd_taken && upd_pred_taken &&
                    (upd_pred_target != up_tgt));
   assign wr_en  = upd_en && !flush;

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = '0;
      end else if (upd_en && upd_taken) begin
         valid_d[up_idx] = 1'b1;
`ifndef BTB_SAT_COUNTER_EN
      end else if (upd_en && up_hit) begin
         valid_d[up_idx] = 1'b0;
`endif
      end
   end

   assign mis_d   = upd_en && cond;
   assign redir_d = !upd_en   ? redir_q :
                    upd_taken ? up_tgt  :
                    upd_pc + ADDR_W'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         mis_q   <= 1'b0;
         redir_q <= '0;
      end else begin
         valid_q <= valid_d;
         mis_q   <= mis_d;
         redir_q <= redir_d;
      end
   end

   // Payload needs no reset; valid gates every use of it.
   always_ff @(posedge clk) begin
      if (!rst && wr_en && upd_taken) begin
         tag_q[up_idx] <= up_tag;
         tgt_q[up_idx] <= up_tgt;
      end
   end

`ifdef BTB_SAT_COUNTER_EN
   ctr_e       ctr_q [ENTRIES];
   ctr_e       ctr_d;
   logic [1:0] lk_ctr;

   always_comb begin
      ctr_d = ctr_q[up_idx];
      if (!up_hit) begin
         ctr_d = CTR_ALLOC;
      end else if (upd_taken) begin
         if (ctr_q[up_idx] != ST)
            ctr_d = ctr_e'(ctr_q[up_idx] + 2'd1);
      end else begin
         if (ctr_q[up_idx] != SNT)
            ctr_d = ctr_e'(ctr_q[up_idx] - 2'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++)
            ctr_q[i] <= CTR_RST;
      end else if (wr_en && (upd_taken || up_hit)) begin
         ctr_q[up_idx] <= ctr_d;
      end
   end

   assign lk_ctr   = ctr_q[lk_idx];
   assign lk_taken = lk_hit && lk_ctr[1];
`else
   assign lk_taken = lk_hit;
`endif

   assign mispredict  = mis_q;
   assign redirect_pc = redir_q;

endmodule
